// File: rtl/p2s.sv
// rtl/p2s.sv - parallel-to-serial transmitter with one-word holding buffer
//
// Purpose:
//   Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding
//   buffer. Shifts each word out one bit per enabled clock. When a word is
//   already held at the end of the current one, the next word follows with no
//   idle bit in between.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: din_i[WIDTH-1] is sent first, 0: din_i[0] is sent first
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   en_i           shift enable; one serial bit advances per enabled edge
//   din_i          parallel word to transmit
//   din_valid_i    din_i is valid this cycle
//   din_ready_o    holding buffer can accept a word (combinational)
//   dout_o         serial data (registered)
//   dout_valid_o   dout_o carries a data bit (registered)
//   frame_start_o  dout_o carries the first bit of a word (registered)
//   busy_o         shifting, or a word is waiting in the holding buffer

module p2s #(
  parameter int unsigned WIDTH     = 10,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             frame_start_o,
  output logic             busy_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_start_q, frame_start_d;

  logic             accept;

  // The shifter holds the bits still to be sent; the bit on dout_o has already
  // been taken out of it, so the next bit always sits at the outgoing end.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign din_ready_o   = !hold_full_q && !rst_i;
  assign accept        = din_valid_i && din_ready_o;
  assign dout_o        = dout_q;
  assign dout_valid_o  = dout_valid_q;
  assign frame_start_o = frame_start_q;
  assign busy_o        = (state_q == SHIFT) || hold_full_q;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    frame_start_d = frame_start_q;

    if (en_i) begin
      // A load happens both from IDLE and at the end of a word, which is what
      // makes consecutive words contiguous on the line.
      if (state_q == SHIFT && cnt_q < LAST) begin
        cnt_d         = cnt_q + CW'(1);
        dout_d        = first_bit(shreg_q);
        shreg_d       = shift_out(shreg_q);
        frame_start_d = 1'b0;
      end else if (hold_full_q) begin
        state_d       = SHIFT;
        cnt_d         = '0;
        dout_d        = first_bit(hold_q);
        shreg_d       = shift_out(hold_q);
        hold_full_d   = 1'b0;
        dout_valid_d  = 1'b1;
        frame_start_d = 1'b1;
      end else begin
        state_d       = IDLE;
        cnt_d         = '0;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
      end
    end

    // accept requires an empty buffer, so it can never collide with the load
    // above, which requires a full one.
    if (accept) begin
      hold_d      = din_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_p2s.sv
// tb/tb_p2s.sv - self-checking bench for p2s, both bit orders side by side

module tb_p2s;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         dv = 1'b0;
  logic [W-1:0] din = '0;

  logic rdy_m, dout_m, vld_m, fs_m, busy_m;
  logic rdy_l, dout_l, vld_l, fs_l, busy_l;

  p2s #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din), .din_valid_i(dv),
    .din_ready_o(rdy_m), .dout_o(dout_m), .dout_valid_o(vld_m),
    .frame_start_o(fs_m), .busy_o(busy_m)
  );

  p2s #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din), .din_valid_i(dv),
    .din_ready_o(rdy_l), .dout_o(dout_l), .dout_valid_o(vld_l),
    .frame_start_o(fs_l), .busy_o(busy_l)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a word in flight is described by the word itself and the
  // index of the bit currently on the line; the buffer is a word plus a flag.
  bit           m_active = 1'b0;
  int           m_pos = 0;
  logic [W-1:0] m_word = '0;
  bit           m_hold_full = 1'b0;
  logic [W-1:0] m_hold = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic mbit(input logic [W-1:0] w, input int pos, input bit msb);
    return msb ? w[W-1-pos] : w[pos];
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic v, input logic [W-1:0] d);
    bit acc;
    if (r) begin
      m_active = 1'b0; m_pos = 0; m_word = '0; m_hold_full = 1'b0; m_hold = '0;
    end else begin
      acc = v && !m_hold_full;
      if (e) begin
        if (m_active && m_pos < W - 1) begin
          m_pos++;
        end else if (m_hold_full) begin
          m_word = m_hold; m_pos = 0; m_active = 1'b1; m_hold_full = 1'b0;
        end else begin
          m_active = 1'b0; m_pos = 0;
        end
      end
      if (acc) begin
        m_hold = d; m_hold_full = 1'b1;
      end
    end
  endtask

  // One clock: apply inputs, check the handshake, clock, check registered outputs.
  task automatic cycle(input logic r, input logic e, input logic v, input logic [W-1:0] d,
                       output bit acc);
    logic exp_rdy;
    rst = r; en = e; dv = v; din = d;
    #1;
    exp_rdy = !m_hold_full && !r;
    check("din_ready", 32'({rdy_m, rdy_l}), 32'({exp_rdy, exp_rdy}));
    acc = v && exp_rdy;
    @(posedge clk);
    model_edge(r, e, v, d);
    #1;
    check("dout_valid", 32'({vld_m, vld_l}), 32'({m_active, m_active}));
    check("frame_start", 32'({fs_m, fs_l}),
          32'({m_active && m_pos == 0, m_active && m_pos == 0}));
    check("busy", 32'({busy_m, busy_l}),
          32'({m_active || m_hold_full, m_active || m_hold_full}));
    check("dout_msb", 32'(dout_m), 32'(m_active ? mbit(m_word, m_pos, 1'b1) : 1'b0));
    check("dout_lsb", 32'(dout_l), 32'(m_active ? mbit(m_word, m_pos, 1'b0) : 1'b0));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, '0, acc);
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle(1'b0, 1'b1, 1'b1, w, acc);
      done = acc;
    end
    check("send_accepted", 32'(done), 32'(1));
  endtask

  initial begin
    bit           acc;
    logic [W-1:0] rx_m;
    logic [W-1:0] rx_l;
    logic [W-1:0] t2_word;
    logic [1:0]   en_pat [4];
    bit           hold_v;
    logic [W-1:0] hold_d;
    logic         r_r, r_e;

    // 1: reset for three clocks, then release
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0, acc);
    idle(2);

    // 2: a single word, checked as a reassembled word in both bit orders
    t2_word = 10'b1011001110;
    cycle(1'b0, 1'b1, 1'b1, t2_word, acc);
    check("t2_accept", 32'(acc), 32'(1));
    rx_m = '0; rx_l = '0;
    for (int i = 0; i < W; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, acc);
      rx_m = {rx_m[W-2:0], dout_m};
      rx_l = {dout_l, rx_l[W-1:1]};
    end
    check("t2_word_msb", 32'(rx_m), 32'(t2_word));
    check("t2_word_lsb", 32'(rx_l), 32'(t2_word));
    idle(3);

    // 3: two words back to back
    send(10'h2A5);
    send(10'h15A);
    idle(25);

    // 4: a shifting word, a held word and a third offered word
    send(10'h3FF);
    send(10'h001);
    send(10'h155);
    idle(35);

    // 5: enable pattern 1,0,0,1 while a word shifts
    en_pat[0] = 2'b1; en_pat[1] = 2'b0; en_pat[2] = 2'b0; en_pat[3] = 2'b1;
    send(10'h2C3);
    for (int i = 0; i < 48; i++) cycle(1'b0, en_pat[i % 4][0], 1'b0, '0, acc);
    idle(4);

    // 6: reset in the middle of a word with another word held
    send(10'h1E7);
    send(10'h0F0);
    idle(4);
    cycle(1'b1, 1'b1, 1'b0, '0, acc);
    cycle(1'b0, 1'b1, 1'b0, '0, acc);
    check("t6_valid_after_rst", 32'(vld_m), 32'(0));
    check("t6_busy_after_rst", 32'(busy_m), 32'(0));
    idle(15);

    // Random traffic: a stalled offer keeps its word until taken
    hold_v = 1'b0;
    hold_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold_v) begin
        hold_v = ($urandom_range(0, 1) == 1);
        hold_d = W'($urandom);
      end
      r_r = ($urandom_range(0, 199) == 0);
      r_e = ($urandom_range(0, 4) != 0);
      cycle(r_r, r_e, hold_v, hold_d, acc);
      if (acc || r_r) hold_v = 1'b0;
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
